// File: rtl/uncache_ctrl.sv
// -----------------------------------------------------------------------------
// uncache_ctrl
//
// Sequencer for uncached data-side accesses. Sits between the pipeline's
// SRAM-like data port and the AXI bridge. Each uncached request becomes one
// single-beat AXI read or write. The pipeline is stalled until that transfer
// completes. The block also drives the refresh/hit/cached controls of the
// external holding register that presents uncached read data to the pipeline.
//
// Ports
//   clk, rst                  clock and synchronous active-high reset
//   req, wr, cached           pipeline request valid, store/load, cacheable
//   addr, size, wstrb, wdata  request fields, latched when the request is accepted
//   stall                     pipeline hold
//   rd_req/rd_addr/rd_size    read request to the bridge
//   rd_rdy                    bridge accepted the read request
//   ret_valid                 read data beat valid (data goes to the holding reg)
//   wr_req/wr_addr/wr_size/wr_strb/wr_data   write request to the bridge
//   wr_rdy, wr_resp           bridge accepted the write / write response seen
//   refresh                   load pulse for the holding register
//   data_hit, data_cached     holding register hit / cached flags
// -----------------------------------------------------------------------------
module uncache_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic        cached,
    input  logic [31:0] addr,
    input  logic [1:0]  size,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        rd_req,
    output logic [31:0] rd_addr,
    output logic [1:0]  rd_size,
    input  logic        rd_rdy,
    input  logic        ret_valid,
    output logic        wr_req,
    output logic [31:0] wr_addr,
    output logic [1:0]  wr_size,
    output logic [3:0]  wr_strb,
    output logic [31:0] wr_data,
    input  logic        wr_rdy,
    input  logic        wr_resp,
    output logic        refresh,
    output logic        data_hit,
    output logic        data_cached
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_REQ  = 3'd1,
        S_RD_WAIT = 3'd2,
        S_WR_REQ  = 3'd3,
        S_WR_WAIT = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q,  addr_d;
    logic [1:0]  size_q,  size_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] wdata_q, wdata_d;
    // Latched operation: 1 = write. This lets DONE tell a read completion
    // from a write completion.
    logic        op_wr_q, op_wr_d;

    logic        new_req_s;

    assign new_req_s = req & ~cached;

    // Next-state and request-field latching.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        wstrb_d = wstrb_q;
        wdata_d = wdata_q;
        op_wr_d = op_wr_q;
        case (state_q)
            S_IDLE: begin
                if (new_req_s) begin
                    addr_d  = addr;
                    size_d  = size;
                    wstrb_d = wstrb;
                    wdata_d = wdata;
                    op_wr_d = wr;
                    state_d = wr ? S_WR_REQ : S_RD_REQ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD_REQ: begin
                if (rd_rdy) begin
                    state_d = S_RD_WAIT;
                end else begin
                    state_d = S_RD_REQ;
                end
            end
            S_RD_WAIT: begin
                if (ret_valid) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RD_WAIT;
                end
            end
            S_WR_REQ: begin
                if (wr_rdy) begin
                    state_d = S_WR_WAIT;
                end else begin
                    state_d = S_WR_REQ;
                end
            end
            S_WR_WAIT: begin
                if (wr_resp) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_WR_WAIT;
                end
            end
            // req in DONE is still the completing request, so return to
            // IDLE unconditionally and never restart from here.
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and latched-field registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= 32'h0000_0000;
            size_q  <= 2'd0;
            wstrb_q <= 4'h0;
            wdata_q <= 32'h0000_0000;
            op_wr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            wstrb_q <= wstrb_d;
            wdata_q <= wdata_d;
            op_wr_q <= op_wr_d;
        end
    end

    // Output decode. The request strobes and hit flags are functions of the
    // registered state. stall and refresh also need same-cycle inputs: the
    // pipeline must hold in the accepting IDLE cycle, and the holding
    // register loads in the cycle the beat arrives.
    always_comb begin
        stall       = 1'b0;
        rd_req      = 1'b0;
        wr_req      = 1'b0;
        refresh     = 1'b0;
        data_hit    = 1'b0;
        data_cached = 1'b1;
        case (state_q)
            S_IDLE:    stall = new_req_s;
            S_RD_REQ: begin
                stall  = 1'b1;
                rd_req = 1'b1;
            end
            S_RD_WAIT: begin
                stall   = 1'b1;
                refresh = ret_valid;
            end
            S_WR_REQ: begin
                stall  = 1'b1;
                wr_req = 1'b1;
            end
            S_WR_WAIT: stall = 1'b1;
            S_DONE: begin
                data_hit    = ~op_wr_q;
                data_cached = op_wr_q;
            end
            default: stall = 1'b0;
        endcase
    end

    assign rd_addr = addr_q;
    assign rd_size = size_q;
    assign wr_addr = addr_q;
    assign wr_size = size_q;
    assign wr_strb = wstrb_q;
    assign wr_data = wdata_q;

endmodule

// File: tb/tb_uncache_ctrl.sv
module tb_uncache_ctrl;

    logic        clk = 1'b0;
    logic        rst, req, wr, cached;
    logic [31:0] addr, wdata;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic        stall, rd_req, wr_req, refresh, data_hit, data_cached;
    logic [31:0] rd_addr, wr_addr, wr_data;
    logic [1:0]  rd_size, wr_size;
    logic [3:0]  wr_strb;
    logic        rd_rdy, ret_valid, wr_rdy, wr_resp;
    logic [31:0] ret_data;
    logic [31:0] hold_q;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    uncache_ctrl dut (
        .clk(clk), .rst(rst), .req(req), .wr(wr), .cached(cached),
        .addr(addr), .size(size), .wstrb(wstrb), .wdata(wdata),
        .stall(stall), .rd_req(rd_req), .rd_addr(rd_addr), .rd_size(rd_size),
        .rd_rdy(rd_rdy), .ret_valid(ret_valid), .wr_req(wr_req),
        .wr_addr(wr_addr), .wr_size(wr_size), .wr_strb(wr_strb),
        .wr_data(wr_data), .wr_rdy(wr_rdy), .wr_resp(wr_resp),
        .refresh(refresh), .data_hit(data_hit), .data_cached(data_cached)
    );

    // Model of the external uncached read-data holding register.
    always @(posedge clk) begin
        if (rst) hold_q <= 32'h0;
        else if (refresh) hold_q <= ret_data;
    end

    // Control outputs packed for compact comparison:
    // {stall, rd_req, wr_req, refresh, data_hit, data_cached}
    function automatic logic [5:0] ctl();
        return {stall, rd_req, wr_req, refresh, data_hit, data_cached};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req = 1'b0; wr = 1'b0; cached = 1'b0; addr = 32'h0; size = 2'd0;
        wstrb = 4'h0; wdata = 32'h0; rd_rdy = 1'b0; ret_valid = 1'b0;
        wr_rdy = 1'b0; wr_resp = 1'b0; ret_data = 32'h0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        @(negedge clk);
        total_cnt++;
        if (ctl() !== 6'b000001) $display("FAIL reset_ctl got=%b exp=%b", ctl(), 6'b000001);
        else pass_cnt++;
        total_cnt++;
        if ({rd_addr, wr_addr, wr_data, rd_size, wr_size, wr_strb} !== 104'h0)
            $display("FAIL reset_fields got=%h/%h/%h/%h/%h/%h exp=0",
                     rd_addr, wr_addr, wr_data, rd_size, wr_size, wr_strb);
        else pass_cnt++;
        step();
        rst = 1'b0;
    endtask

    task automatic test_uncached_load();
        // c0
        req = 1'b1; wr = 1'b0; cached = 1'b0; addr = 32'hBFD0_0010; size = 2'd2;
        @(negedge clk);
        total_cnt++;
        if (ctl() !== 6'b100001) $display("FAIL ld_c0 got=%b exp=%b", ctl(), 6'b100001);
        else pass_cnt++;
        step();
        // c1: RD_REQ
        rd_rdy = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (ctl() !== 6'b110001) $display("FAIL ld_c1 got=%b exp=%b", ctl(), 6'b110001);
        else pass_cnt++;
        total_cnt++;
        if ({rd_addr, rd_size} !== {32'hBFD0_0010, 2'd2})
            $display("FAIL ld_c1_fields got=%h/%0d exp=bfd00010/2", rd_addr, rd_size);
        else pass_cnt++;
        step();
        // c2: RD_WAIT with data
        rd_rdy = 1'b0; ret_valid = 1'b1; ret_data = 32'h1234_5678;
        @(negedge clk);
        total_cnt++;
        if (ctl() !== 6'b100101) $display("FAIL ld_c2 got=%b exp=%b", ctl(), 6'b100101);
        else pass_cnt++;
        step();
        // c3: DONE, req still asserted
        ret_valid = 1'b0; ret_data = 32'h0;
        @(negedge clk);
        total_cnt++;
        if (ctl() !== 6'b000010) $display("FAIL ld_c3 got=%b exp=%b", ctl(), 6'b000010);
        else pass_cnt++;
        step();
        // c4
        req = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (hold_q !== 32'h1234_5678) $display("FAIL ld_c4_hold got=%h exp=%h", hold_q, 32'h1234_5678);
        else pass_cnt++;
        total_cnt++;
        if (ctl() !== 6'b000001) $display("FAIL ld_c4 got=%b exp=%b", ctl(), 6'b000001);
        else pass_cnt++;
        step();
    endtask

    task automatic test_store_delayed();
        req = 1'b1; wr = 1'b1; cached = 1'b0; addr = 32'hBFD0_F000; size = 2'd2;
        wstrb = 4'b0011; wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        total_cnt++;
        if (ctl() !== 6'b100001) $display("FAIL st_c0 got=%b exp=%b", ctl(), 6'b100001);
        else pass_cnt++;
        step();
        for (int i = 0; i < 4; i++) begin
            wr_rdy = (i == 3);
            @(negedge clk);
            total_cnt++;
            if (ctl() !== 6'b101001) $display("FAIL st_req%0d got=%b exp=%b", i, ctl(), 6'b101001);
            else pass_cnt++;
            total_cnt++;
            if ({wr_addr, wr_size, wr_strb, wr_data} !== {32'hBFD0_F000, 2'd2, 4'b0011, 32'hDEAD_BEEF})
                $display("FAIL st_fields%0d got=%h/%0d/%b/%h exp=bfd0f000/2/0011/deadbeef",
                         i, wr_addr, wr_size, wr_strb, wr_data);
            else pass_cnt++;
            step();
        end
        wr_rdy = 1'b0;
        for (int j = 0; j < 2; j++) begin
            wr_resp = (j == 1);
            @(negedge clk);
            total_cnt++;
            if (ctl() !== 6'b100001) $display("FAIL st_wait%0d got=%b exp=%b", j, ctl(), 6'b100001);
            else pass_cnt++;
            step();
        end
        wr_resp = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (ctl() !== 6'b000001) $display("FAIL st_done got=%b exp=%b", ctl(), 6'b000001);
        else pass_cnt++;
        step();
        req = 1'b0; wr = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (ctl() !== 6'b000001) $display("FAIL st_after got=%b exp=%b", ctl(), 6'b000001);
        else pass_cnt++;
        step();
    endtask

    task automatic test_cached_stream();
        int bad = 0;
        req = 1'b1; cached = 1'b1; addr = 32'h8000_0040; size = 2'd2;
        for (int i = 0; i < 10; i++) begin
            wr = i[0];
            @(negedge clk);
            if (ctl() !== 6'b000001) bad++;
            step();
        end
        total_cnt++;
        if (bad !== 0) $display("FAIL cached_stream bad_cycles=%0d exp=0", bad);
        else pass_cnt++;
        req = 1'b0; cached = 1'b0; wr = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (ctl() !== 6'b000001) $display("FAIL cached_after got=%b exp=%b", ctl(), 6'b000001);
        else pass_cnt++;
        step();
    endtask

    task automatic test_back_to_back();
        int hs = 0;
        int rf = 0;
        logic [31:0] data_v [2];
        data_v[0] = 32'hAAAA_0001;
        data_v[1] = 32'hAAAA_0002;
        rd_rdy = 1'b1;
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < 4; c++) begin
                req = 1'b1; wr = 1'b0; cached = 1'b0;
                addr = 32'hBFD0_0100 + 32'(k * 4); size = 2'd2;
                ret_valid = (c == 2);
                ret_data = (c == 2) ? data_v[k] : 32'h0;
                @(negedge clk);
                if (rd_req && rd_rdy) hs++;
                if (refresh) rf++;
                if (c == 0 && k == 1) begin
                    total_cnt++;
                    if (hold_q !== 32'hAAAA_0001) $display("FAIL b2b_hold1 got=%h exp=%h", hold_q, 32'hAAAA_0001);
                    else pass_cnt++;
                    total_cnt++;
                    if (stall !== 1'b1) $display("FAIL b2b_second_stall got=%b exp=1", stall);
                    else pass_cnt++;
                end
                step();
            end
        end
        req = 1'b0; ret_valid = 1'b0; ret_data = 32'h0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (rd_req && rd_rdy) hs++;
            if (refresh) rf++;
            step();
        end
        rd_rdy = 1'b0;
        total_cnt++;
        if (hs !== 2) $display("FAIL b2b_handshakes got=%0d exp=2", hs);
        else pass_cnt++;
        total_cnt++;
        if (rf !== 2) $display("FAIL b2b_refresh got=%0d exp=2", rf);
        else pass_cnt++;
        total_cnt++;
        if (hold_q !== 32'hAAAA_0002) $display("FAIL b2b_hold2 got=%h exp=%h", hold_q, 32'hAAAA_0002);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_transfer();
        req = 1'b1; wr = 1'b0; cached = 1'b0; addr = 32'hBFD0_0200; size = 2'd1;
        step();
        rd_rdy = 1'b1;
        step();
        // RD_WAIT: assert reset
        rd_rdy = 1'b0; rst = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (stall !== 1'b1) $display("FAIL rstmid_in_wait got=%b exp=1", stall);
        else pass_cnt++;
        step();
        rst = 1'b0; req = 1'b0; ret_valid = 1'b1; ret_data = 32'h5555_5555;
        @(negedge clk);
        total_cnt++;
        if (ctl() !== 6'b000001) $display("FAIL rstmid_ctl got=%b exp=%b", ctl(), 6'b000001);
        else pass_cnt++;
        total_cnt++;
        if ({rd_addr, rd_size} !== 34'h0) $display("FAIL rstmid_fields got=%h/%0d exp=0/0", rd_addr, rd_size);
        else pass_cnt++;
        step();
        ret_valid = 1'b0; ret_data = 32'h0;
        @(negedge clk);
        total_cnt++;
        if (hold_q !== 32'h0) $display("FAIL rstmid_hold got=%h exp=0", hold_q);
        else pass_cnt++;
        step();
    endtask

    task automatic test_spurious_ret();
        // IDLE, no request, stray beat
        ret_valid = 1'b1; ret_data = 32'h0BAD_0001;
        @(negedge clk);
        total_cnt++;
        if (ctl() !== 6'b000001) $display("FAIL spur_idle got=%b exp=%b", ctl(), 6'b000001);
        else pass_cnt++;
        step();
        // IDLE accepting a load, stray beat
        req = 1'b1; wr = 1'b0; cached = 1'b0; addr = 32'hBFD0_0300; size = 2'd0;
        @(negedge clk);
        total_cnt++;
        if (ctl() !== 6'b100001) $display("FAIL spur_accept got=%b exp=%b", ctl(), 6'b100001);
        else pass_cnt++;
        step();
        // RD_REQ, bridge not ready
        @(negedge clk);
        total_cnt++;
        if (ctl() !== 6'b110001) $display("FAIL spur_rdreq0 got=%b exp=%b", ctl(), 6'b110001);
        else pass_cnt++;
        step();
        // RD_REQ, bridge ready, still a stray beat
        rd_rdy = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (ctl() !== 6'b110001) $display("FAIL spur_rdreq1 got=%b exp=%b", ctl(), 6'b110001);
        else pass_cnt++;
        step();
        // RD_WAIT, beat late by one cycle
        rd_rdy = 1'b0; ret_valid = 1'b0; ret_data = 32'h0;
        @(negedge clk);
        total_cnt++;
        if (ctl() !== 6'b100001) $display("FAIL spur_wait got=%b exp=%b", ctl(), 6'b100001);
        else pass_cnt++;
        step();
        ret_valid = 1'b1; ret_data = 32'h0000_00C3;
        @(negedge clk);
        total_cnt++;
        if (ctl() !== 6'b100101) $display("FAIL spur_ret got=%b exp=%b", ctl(), 6'b100101);
        else pass_cnt++;
        step();
        ret_valid = 1'b0; ret_data = 32'h0;
        @(negedge clk);
        total_cnt++;
        if (ctl() !== 6'b000010) $display("FAIL spur_done got=%b exp=%b", ctl(), 6'b000010);
        else pass_cnt++;
        step();
        req = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (hold_q !== 32'h0000_00C3) $display("FAIL spur_hold got=%h exp=%h", hold_q, 32'h0000_00C3);
        else pass_cnt++;
        step();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_uncached_load();
        test_store_delayed();
        test_cached_stream();
        test_back_to_back();
        test_reset_mid_transfer();
        test_spurious_ret();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
